uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the depth of the receive-echo byte FIFO (power of two, min 2).
REQ-002 The block SHALL have parameter RTS_MARGIN, default 1, meaning the number of free FIFO entries at or below which rts is deasserted.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 rx_valid  in  1  one-cycle strobe from the receiver: a byte is available; no backpressure.
REQ-006 rx_data  in  8  received byte, qualified by rx_valid.
REQ-007 msg_valid  in  1  status/diagnostic requester has a byte to send.
REQ-008 msg_data  in  8  status byte, stable while msg_valid=1 and msg_ready=0.
REQ-009 msg_ready  out  1  handshake accept; a transfer occurs when msg_valid and msg_ready are both 1.
REQ-010 cts  in  1  host CTS#, active-low; 1 blocks new transmissions.
REQ-011 rts  out  1  RTS# to host, active-low; 0 means the block can accept bytes.
REQ-012 tx_start  out  1  one-cycle launch pulse to the serializer.
REQ-013 tx_data  out  8  byte for the serializer; held stable from tx_start until tx_busy falls.
REQ-014 tx_busy  in  1  serializer busy flag.
REQ-015 grant_id  out  1  source of the current/last launched byte: 0 = echo FIFO, 1 = msg.
REQ-016 overflow  out  1  sticky flag: an rx byte was dropped.

Function
REQ-017 On each rx_valid, rx_data SHALL be pushed into the echo FIFO in the same cycle.
REQ-018 A push to a full FIFO SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted and the count SHALL stay at FIFO_DEPTH.
REQ-019 overflow SHALL remain 1 until reset.
REQ-020 rts SHALL be registered: 1 when free entries <= RTS_MARGIN, otherwise 0, updated one cycle after the count changes.
REQ-021 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-022 In IDLE with cts=0 and at least one source pending, the FSM SHALL grant, latch tx_data and grant_id, and enter LAUNCH on the next edge.
REQ-023 The echo source is pending when the FIFO is non-empty; msg is pending when msg_valid=1.
REQ-024 With both sources pending, the grant SHALL go to the source not granted last (round-robin).
REQ-025 With one source pending, the grant SHALL go to that source.
REQ-026 An echo grant SHALL pop the FIFO in the grant cycle.
REQ-027 A msg grant SHALL assert msg_ready for exactly that grant cycle, and msg_ready SHALL be 0 at all other times.
REQ-028 In IDLE with cts=1, the FSM SHALL not grant, and pending bytes SHALL be held.
REQ-029 In LAUNCH, the block SHALL assert tx_start for exactly one cycle, then enter WAIT_BUSY.
REQ-030 In WAIT_BUSY, the FSM SHALL enter WAIT_DONE when tx_busy=1.
REQ-031 In WAIT_DONE, the FSM SHALL return to IDLE when tx_busy=0.
REQ-032 The earliest next grant SHALL occur in the IDLE cycle following tx_busy falling.
REQ-033 A cts change to 1 during LAUNCH, WAIT_BUSY or WAIT_DONE SHALL not abort the byte in flight.
REQ-034 The minimum latency from rx_valid (empty FIFO, idle, cts=0) to tx_start SHALL be 2 cycles: push at edge 1, grant at edge 2, tx_start high during the following cycle.

Reset
REQ-035 While reset=0 at a clock edge, the block SHALL go to state IDLE, FIFO count 0, pointers 0, overflow=0, rts=0, tx_start=0, msg_ready=0, tx_data=8'h00, grant_id=0, and last-grant=1 (echo wins the first tie).
REQ-036 Reset asserted mid-transmission SHALL discard FIFO contents and the latched byte, and no tx_start SHALL follow until a new grant.

Structure
REQ-037 The state enumeration and default FIFO_DEPTH/RTS_MARGIN constants SHALL live in shared package uart_pkg.
REQ-038 The echo FIFO SHALL be a sub-module uart_byte_fifo with push/pop/full/empty/count ports and the same clk/reset.

Verification
REQ-039 Single echo: rx_valid with 8'hA5, cts=0, serializer busy for 10 cycles -> one tx_start 2 cycles later with tx_data=8'hA5, grant_id=0, FSM back to IDLE after busy falls.
REQ-040 Contention: FIFO holds 8'h11 and 8'h22, msg_valid with 8'h4D held -> launch order 8'h11, 8'h4D, 8'h22; msg_ready pulses once.
REQ-041 Flow control: cts=1 while 3 bytes are pushed -> no tx_start; after cts=0, the 3 bytes are sent in order.
REQ-042 Overflow/RTS: cts=1 with FIFO_DEPTH=4; 3 pushes -> rts=1; 5th push -> dropped, overflow=1, FIFO contents equal the first 4 bytes.
REQ-043 Simultaneous push and pop on a full FIFO -> count stays 4, no overflow, new byte delivered last.
REQ-044 Reset during WAIT_DONE with 2 bytes queued -> all outputs at reset values, and no tx_start after release until a new rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its echo FIFO.
// Holds the FSM state enumeration, grant-source encodings and the round-robin pick.
package uart_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RTS_MARGIN_DEF = 1;

  localparam logic SRC_ECHO = 1'b0;
  localparam logic SRC_MSG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // On a tie the source that did not win last time gets the grant.
  function automatic logic pick_src(input logic echo_pend, input logic msg_pend,
                                    input logic last_src);
    if (echo_pend && msg_pend) return ~last_src;
    return msg_pend ? SRC_MSG : SRC_ECHO;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for received bytes waiting to be echoed; power-of-two depth.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between the receive-echo FIFO and a status-byte
// requester, with round-robin arbitration, CTS#/RTS# flow control and overflow flag.
//
// state     | meaning
// IDLE      | may grant when cts=0 and a source is pending
// LAUNCH    | tx_start high for one cycle, byte latched on tx_data
// WAIT_BUSY | waiting for the serializer to raise tx_busy
// WAIT_DONE | waiting for tx_busy to fall
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RTS_MARGIN = RTS_MARGIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       msg_valid,
  input  logic [7:0] msg_data,
  output logic       msg_ready,
  input  logic       cts,
  output logic       rts,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          grant;
  logic          grant_src;
  logic          last_grant;
  logic          rts_nxt;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rts_nxt = (FIFO_DEPTH - int'(fifo_count)) <= RTS_MARGIN;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_src = pick_src(!fifo_empty, msg_valid, last_grant);
    fifo_pop  = 1'b0;
    msg_ready = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no handshake leaks out while reset is held.
        if (reset && !cts && (!fifo_empty || msg_valid)) begin
          grant     = 1'b1;
          fifo_pop  = (grant_src == SRC_ECHO);
          msg_ready = (grant_src == SRC_MSG);
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      grant_id   <= SRC_ECHO;
      last_grant <= SRC_MSG;
      overflow   <= 1'b0;
      rts        <= 1'b0;
    end else begin
      state <= state_nxt;
      rts   <= rts_nxt;
      if (grant) begin
        tx_data    <= (grant_src == SRC_MSG) ? msg_data : fifo_head;
        grant_id   <= grant_src;
        last_grant <= grant_src;
      end
      if (rx_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic,
// all cycles compared against a queue-based model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       msg_valid;
  logic [7:0] msg_data;
  logic       msg_ready;
  logic       cts;
  logic       rts;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_id;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_ready (msg_ready),
    .cts       (cts),
    .rts       (rts),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus for the next cycle
  logic       s_rst = 1'b0;
  logic       s_rxv = 1'b0;
  logic [7:0] s_rxd = 8'h00;
  logic       s_mv  = 1'b0;
  logic [7:0] s_md  = 8'h00;
  logic       s_cts = 1'b0;

  // serializer model: busy during cycles [bs, be)
  bit ser_rand = 1'b0;
  int ser_d = 0;
  int ser_l = 10;
  int bs = -1;
  int be = -1;

  // reference model
  logic [7:0] mq[$];
  bit         m_ovf, m_rts, m_start, m_gid, m_last, m_in, m_seen;
  logic [7:0] m_data;

  // launches observed on the DUT
  int         l_cyc[$];
  logic [7:0] l_data[$];
  bit         l_gid[$];
  int         mr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit busy, grant, src, pop;
    logic [7:0] popped;
    popped = 8'h00;
    @(negedge clk);
    busy      = (cyc >= bs) && (cyc < be);
    reset     = s_rst;
    rx_valid  = s_rxv;
    rx_data   = s_rxd;
    msg_valid = s_mv;
    msg_data  = s_md;
    cts       = s_cts;
    tx_busy   = busy;
    #1;
    grant = s_rst && !m_in && !s_cts && (mq.size() > 0 || s_mv);
    if (mq.size() > 0 && s_mv) src = !m_last;
    else                       src = (mq.size() == 0);
    check("tx_start",  32'(tx_start),  32'(m_start));
    check("tx_data",   32'(tx_data),   32'(m_data));
    check("grant_id",  32'(grant_id),  32'(m_gid));
    check("rts",       32'(rts),       32'(m_rts));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("msg_ready", 32'(msg_ready), 32'(grant && src));
    if (tx_start) begin
      l_cyc.push_back(cyc);
      l_data.push_back(tx_data);
      l_gid.push_back(grant_id);
      if (ser_rand) begin
        ser_d = $urandom_range(0, 2);
        ser_l = $urandom_range(1, 6);
      end
      bs = cyc + 1 + ser_d;
      be = bs + ser_l;
    end
    if (msg_ready) mr_cnt++;
    if (!s_rst) begin
      mq.delete();
      m_ovf = 0; m_rts = 0; m_start = 0; m_data = 8'h00;
      m_gid = 0; m_last = 1; m_in = 0; m_seen = 0;
    end else begin
      m_rts = (DEPTH - mq.size()) <= MARGIN;
      if (m_in && !m_start) begin
        if (!m_seen) begin
          if (busy) m_seen = 1;
        end else if (!busy) begin
          m_in = 0;
          m_seen = 0;
        end
      end
      m_start = grant;
      pop = grant && !src;
      if (pop) popped = mq.pop_front();
      if (s_rxv) begin
        if (mq.size() < DEPTH) mq.push_back(s_rxd);
        else m_ovf = 1;
      end
      if (grant) begin
        m_data = src ? s_md : popped;
        m_gid  = src;
        m_last = src;
        m_in   = 1;
        m_seen = 0;
      end
    end
    if (msg_ready && s_mv) s_mv = 1'b0;
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    s_rxv = 1'b1;
    s_rxd = b;
    step();
    s_rxv = 1'b0;
  endtask

  task automatic do_reset();
    s_rst = 1'b0;
    step();
    step();
    s_rst = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int base, c0, mr0;
  logic [7:0] b[5];
  logic [7:0] nb;

  initial begin
    // reset values
    do_reset();
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_rts", 32'(rts), 32'h0);

    // single echo, busy 10 cycles
    ser_d = 0; ser_l = 10;
    base = l_cyc.size();
    c0 = cyc;
    push(8'hA5);
    run(25);
    check("echo_count", 32'(l_cyc.size() - base), 32'd1);
    if (l_cyc.size() > base) begin
      check("echo_latency", 32'(l_cyc[base] - c0), 32'd2);
      check("echo_data", 32'(l_data[base]), 32'hA5);
      check("echo_gid", 32'(l_gid[base]), 32'd0);
    end

    // contention: 11, 22 queued plus msg 4D
    do_reset();
    ser_d = 1; ser_l = 3;
    s_cts = 1'b1;
    push(8'h11);
    push(8'h22);
    s_mv = 1'b1; s_md = 8'h4D;
    step();
    base = l_cyc.size();
    mr0 = mr_cnt;
    s_cts = 1'b0;
    run(60);
    check("rr_count", 32'(l_cyc.size() - base), 32'd3);
    if (l_cyc.size() >= base + 3) begin
      check("rr_0", 32'(l_data[base]),   32'h11);
      check("rr_1", 32'(l_data[base+1]), 32'h4D);
      check("rr_2", 32'(l_data[base+2]), 32'h22);
      check("rr_gid1", 32'(l_gid[base+1]), 32'd1);
    end
    check("rr_msg_ready", 32'(mr_cnt - mr0), 32'd1);

    // flow control
    do_reset();
    s_cts = 1'b1;
    base = l_cyc.size();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    run(6);
    check("cts_hold", 32'(l_cyc.size() - base), 32'd0);
    s_cts = 1'b0;
    run(40);
    check("cts_count", 32'(l_cyc.size() - base), 32'd3);
    if (l_cyc.size() >= base + 3)
      for (int i = 0; i < 3; i++) check("cts_order", 32'(l_data[base+i]), 32'(b[i]));

    // overflow and rts
    do_reset();
    s_cts = 1'b1;
    base = l_cyc.size();
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    push(b[0]); push(b[1]);
    push(b[2]);
    step();
    step();
    check("rts_at_margin", 32'(rts), 32'd1);
    check("no_ovf_yet", 32'(overflow), 32'd0);
    push(b[3]);
    push(b[4]);
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    s_cts = 1'b0;
    run(50);
    check("ovf_count", 32'(l_cyc.size() - base), 32'd4);
    if (l_cyc.size() >= base + 4)
      for (int i = 0; i < 4; i++) check("ovf_order", 32'(l_data[base+i]), 32'(b[i]));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // push and pop on a full FIFO in the same cycle
    do_reset();
    s_cts = 1'b1;
    base = l_cyc.size();
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    step();
    nb = 8'($urandom);
    s_cts = 1'b0;
    push(nb);
    run(60);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_count", 32'(l_cyc.size() - base), 32'd5);
    if (l_cyc.size() >= base + 5) begin
      for (int i = 0; i < 4; i++) check("pp_order", 32'(l_data[base+i]), 32'(b[i]));
      check("pp_last", 32'(l_data[base+4]), 32'(nb));
    end

    // reset during WAIT_DONE with two bytes queued
    do_reset();
    ser_d = 0; ser_l = 10;
    push(8'hC1); push(8'hC2); push(8'hC3);
    run(4);
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    step();
    check("wr_tx_start", 32'(tx_start), 32'd0);
    check("wr_tx_data", 32'(tx_data), 32'h00);
    check("wr_gid", 32'(grant_id), 32'd0);
    check("wr_rts", 32'(rts), 32'd0);
    check("wr_msg_ready", 32'(msg_ready), 32'd0);
    base = l_cyc.size();
    run(30);
    check("wr_quiet", 32'(l_cyc.size() - base), 32'd0);
    push(8'h3C);
    run(5);
    check("wr_new_count", 32'(l_cyc.size() - base), 32'd1);
    if (l_cyc.size() > base) check("wr_new_data", 32'(l_data[base]), 32'h3C);

    // random traffic
    do_reset();
    ser_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      s_rxv = ($urandom_range(0, 99) < 30);
      s_rxd = 8'($urandom);
      if (!s_mv && $urandom_range(0, 99) < 15) begin
        s_mv = 1'b1;
        s_md = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 8) s_cts = !s_cts;
      s_rst = !($urandom_range(0, 999) < 3);
      step();
    end
    s_rxv = 1'b0;
    s_rst = 1'b1;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
